// File: rtl/risc_pkg.sv
// Shared constants, ALU opcodes and register update helper
// for the 8-bit accumulator datapath.
package risc_pkg;

   localparam int DATA_W = 8;

   localparam logic [2:0] SEL_NONE = 3'd0;
   localparam logic [2:0] SEL_AR   = 3'd1;
   localparam logic [2:0] SEL_PC   = 3'd2;
   localparam logic [2:0] SEL_DR   = 3'd3;
   localparam logic [2:0] SEL_AC   = 3'd4;
   localparam logic [2:0] SEL_IR   = 3'd5;
   localparam logic [2:0] SEL_TR   = 3'd6;
   localparam logic [2:0] SEL_MEM  = 3'd7;

   typedef enum logic [2:0] {
      ALU_AND     = 3'b000,
      ALU_ADD     = 3'b001,
      ALU_SUB     = 3'b010,
      ALU_OR      = 3'b011,
      ALU_XOR     = 3'b100,
      ALU_PASS_AC = 3'b101,
      ALU_NOT_AC  = 3'b110,
      ALU_PASS_DR = 3'b111
   } alu_mode_t;

   // Clear beats load beats increment; increment wraps mod 256.
   function automatic logic [DATA_W-1:0] reg_next(
      input logic [DATA_W-1:0] q,
      input logic [DATA_W-1:0] d,
      input logic              clr,
      input logic              ld,
      input logic              inc
   );
      logic [DATA_W-1:0] n;
      if (clr)      n = '0;
      else if (ld)  n = d;
      else if (inc) n = q + {{(DATA_W-1){1'b0}}, 1'b1};
      else          n = q;
      return n;
   endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU over AC and DR.
// Carry output exists only with RISC_DATAPATH_FLAGS_EN.
module risc_alu
   import risc_pkg::*;
(
   input  logic [2:0]        alu_mode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
`ifdef RISC_DATAPATH_FLAGS_EN
   output logic              carry,
`endif
   output logic [DATA_W-1:0] result
);

   alu_mode_t op;
   assign op = alu_mode_t'(alu_mode);

`ifdef RISC_DATAPATH_FLAGS_EN
   logic [DATA_W:0] wide;

   always_comb begin
      wide   = '0;
      carry  = 1'b0;
      result = '0;
      unique case (op)
         ALU_AND:     result = a & b;
         ALU_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[DATA_W-1:0];
            carry  = wide[DATA_W];
         end
         // Carry after subtract reads as "no borrow".
         ALU_SUB: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[DATA_W-1:0];
            carry  = ~wide[DATA_W];
         end
         ALU_OR:      result = a | b;
         ALU_XOR:     result = a ^ b;
         ALU_PASS_AC: result = a;
         ALU_NOT_AC:  result = ~a;
         ALU_PASS_DR: result = b;
         default:     result = '0;
      endcase
   end
`else
   always_comb begin
      result = '0;
      unique case (op)
         ALU_AND:     result = a & b;
         ALU_ADD:     result = a + b;
         ALU_SUB:     result = a - b;
         ALU_OR:      result = a | b;
         ALU_XOR:     result = a ^ b;
         ALU_PASS_AC: result = a;
         ALU_NOT_AC:  result = ~a;
         ALU_PASS_DR: result = b;
         default:     result = '0;
      endcase
   end
`endif

endmodule

// File: rtl/risc_datapath.sv
// Common-bus accumulator datapath: registers, bus mux, ALU result reg.
// Define RISC_DATAPATH_FLAGS_EN to add the carry/zero flag outputs.
module risc_datapath
   import risc_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              load_AR,
   input  logic              load_PC,
   input  logic              load_DR,
   input  logic              load_AC,
   input  logic              load_IR,
   input  logic              load_TR,
   input  logic              clear_AR,
   input  logic              clear_PC,
   input  logic              clear_DR,
   input  logic              clear_AC,
   input  logic              clear_TR,
   input  logic              inc_AR,
   input  logic              inc_PC,
   input  logic              inc_DR,
   input  logic              inc_AC,
   input  logic              inc_TR,
   input  logic              memory_read,
   input  logic              memory_write,
   input  logic [2:0]        bus_selectors,
   input  logic              alu_enable,
   input  logic [2:0]        alu_mode,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [DATA_W-1:0] IR,
   output logic [DATA_W-1:0] AC,
   output logic [DATA_W-1:0] PC,
   output logic [DATA_W-1:0] AR,
`ifdef RISC_DATAPATH_FLAGS_EN
   output logic              flag_c,
   output logic              flag_z,
`endif
   output logic [DATA_W-1:0] bus
);

   logic [DATA_W-1:0] DR;
   logic [DATA_W-1:0] TR;
   logic [DATA_W-1:0] R;
   logic [DATA_W-1:0] alu_result;

   always_comb begin
      bus = '0;
      unique case (bus_selectors)
         SEL_NONE: bus = '0;
         SEL_AR:   bus = AR;
         SEL_PC:   bus = PC;
         SEL_DR:   bus = DR;
         SEL_AC:   bus = AC;
         SEL_IR:   bus = IR;
         SEL_TR:   bus = TR;
         SEL_MEM:  bus = memory_read ? mem_rdata : '0;
         default:  bus = '0;
      endcase
   end

   assign mem_addr  = AR;
   assign mem_wdata = bus;
   assign mem_we    = memory_write & ~reset;

`ifdef RISC_DATAPATH_FLAGS_EN
   logic alu_carry;

   risc_alu u_alu (
      .alu_mode (alu_mode),
      .a        (AC),
      .b        (DR),
      .carry    (alu_carry),
      .result   (alu_result)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else if (alu_enable) begin
         flag_c <= alu_carry;
         flag_z <= (alu_result == '0);
      end
   end
`else
   risc_alu u_alu (
      .alu_mode (alu_mode),
      .a        (AC),
      .b        (DR),
      .result   (alu_result)
   );
`endif

   // AC takes R, never the bus; R gives one cycle of ALU latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         AR <= '0;
         PC <= '0;
         DR <= '0;
         AC <= '0;
         IR <= '0;
         TR <= '0;
         R  <= '0;
      end else begin
         AR <= reg_next(AR, bus, clear_AR, load_AR, inc_AR);
         PC <= reg_next(PC, bus, clear_PC, load_PC, inc_PC);
         DR <= reg_next(DR, bus, clear_DR, load_DR, inc_DR);
         AC <= reg_next(AC, R,   clear_AC, load_AC, inc_AC);
         TR <= reg_next(TR, bus, clear_TR, load_TR, inc_TR);
         if (load_IR)    IR <= bus;
         if (alu_enable) R  <= alu_result;
      end
   end

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath with hand-computed expectations.
// Flag checks are built in when RISC_DATAPATH_FLAGS_EN is defined.
module tb_risc_datapath;

   logic       clock = 1'b0;
   logic       reset;
   logic       load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
   logic       clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
   logic       inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
   logic       memory_read, memory_write;
   logic [2:0] bus_selectors;
   logic       alu_enable;
   logic [2:0] alu_mode;
   logic [7:0] mem_rdata;
   logic [7:0] mem_addr, mem_wdata, IR, AC, PC, AR, bus;
   logic       mem_we;
`ifdef RISC_DATAPATH_FLAGS_EN
   logic       flag_c, flag_z;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   risc_datapath dut (
      .clock         (clock),
      .reset         (reset),
      .load_AR       (load_AR),
      .load_PC       (load_PC),
      .load_DR       (load_DR),
      .load_AC       (load_AC),
      .load_IR       (load_IR),
      .load_TR       (load_TR),
      .clear_AR      (clear_AR),
      .clear_PC      (clear_PC),
      .clear_DR      (clear_DR),
      .clear_AC      (clear_AC),
      .clear_TR      (clear_TR),
      .inc_AR        (inc_AR),
      .inc_PC        (inc_PC),
      .inc_DR        (inc_DR),
      .inc_AC        (inc_AC),
      .inc_TR        (inc_TR),
      .memory_read   (memory_read),
      .memory_write  (memory_write),
      .bus_selectors (bus_selectors),
      .alu_enable    (alu_enable),
      .alu_mode      (alu_mode),
      .mem_rdata     (mem_rdata),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .IR            (IR),
      .AC            (AC),
      .PC            (PC),
      .AR            (AR),
`ifdef RISC_DATAPATH_FLAGS_EN
      .flag_c        (flag_c),
      .flag_z        (flag_z),
`endif
      .bus           (bus)
   );

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      load_AR = 0; load_PC = 0; load_DR = 0;
      load_AC = 0; load_IR = 0; load_TR = 0;
      clear_AR = 0; clear_PC = 0; clear_DR = 0;
      clear_AC = 0; clear_TR = 0;
      inc_AR = 0; inc_PC = 0; inc_DR = 0;
      inc_AC = 0; inc_TR = 0;
      memory_read = 0; memory_write = 0;
      bus_selectors = 3'd0;
      alu_enable = 0; alu_mode = 3'd0;
      mem_rdata = 8'h00;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic from_mem(input logic [7:0] v);
      bus_selectors = 3'd7;
      memory_read   = 1;
      mem_rdata     = v;
   endtask

   task automatic alu_op(input logic [2:0] m);
      alu_mode   = m;
      alu_enable = 1;
      tick();
      load_AC = 1;
      tick();
   endtask

   initial begin
      idle();
      reset        = 1;
      memory_write = 1;
      #1;
      chk("mem_we_in_reset", {7'd0, mem_we}, 8'h00);
      repeat (2) @(posedge clock);
      #1;
      chk("rst_AR", AR, 8'h00);
      chk("rst_PC", PC, 8'h00);
      chk("rst_AC", AC, 8'h00);
      chk("rst_IR", IR, 8'h00);
      chk("rst_bus", bus, 8'h00);
`ifdef RISC_DATAPATH_FLAGS_EN
      chk("rst_c", {7'd0, flag_c}, 8'h00);
      chk("rst_z", {7'd0, flag_z}, 8'h00);
`endif
      reset = 0;
      idle();

      from_mem(8'h10); load_PC = 1;
      tick();
      chk("pc_load", PC, 8'h10);

      bus_selectors = 3'd2; load_AR = 1;
      #1;
      chk("bus_pc", bus, 8'h10);
      tick();
      chk("fetch_AR", AR, 8'h10);

      from_mem(8'hA3); load_IR = 1; inc_PC = 1;
      #1;
      chk("bus_mem", bus, 8'hA3);
      tick();
      chk("fetch_IR", IR, 8'hA3);
      chk("fetch_PC", PC, 8'h11);
      chk("fetch_AR2", AR, 8'h10);

      bus_selectors = 3'd7; mem_rdata = 8'h77;
      #1;
      chk("mem_no_read", bus, 8'h00);
      idle();

      from_mem(8'hF0); load_DR = 1;
      tick();
      alu_mode = 3'b111; alu_enable = 1;
      tick();
      chk("alu_latency", AC, 8'h00);
      load_AC = 1;
      tick();
      chk("pass_dr", AC, 8'hF0);

      from_mem(8'h20); load_DR = 1;
      tick();
      bus_selectors = 3'd3;
      #1;
      chk("bus_dr", bus, 8'h20);
      idle();
      alu_op(3'b001);
      chk("add", AC, 8'h10);
`ifdef RISC_DATAPATH_FLAGS_EN
      chk("add_c", {7'd0, flag_c}, 8'h01);
      chk("add_z", {7'd0, flag_z}, 8'h00);
`endif
      alu_op(3'b010);
      chk("sub", AC, 8'hF0);
`ifdef RISC_DATAPATH_FLAGS_EN
      chk("sub_c", {7'd0, flag_c}, 8'h00);
`endif
      alu_op(3'b000);
      chk("and", AC, 8'h20);
      alu_op(3'b100);
      chk("xor", AC, 8'h00);
`ifdef RISC_DATAPATH_FLAGS_EN
      chk("xor_z", {7'd0, flag_z}, 8'h01);
`endif
      alu_op(3'b011);
      chk("or", AC, 8'h20);
      alu_op(3'b110);
      chk("not", AC, 8'hDF);
      alu_mode = 3'b111; load_AC = 1;
      tick();
      chk("r_hold", AC, 8'hDF);

      from_mem(8'h55); clear_PC = 1; load_PC = 1; inc_PC = 1;
      tick();
      chk("prio_clear", PC, 8'h00);
      from_mem(8'h55); load_PC = 1; inc_PC = 1;
      tick();
      chk("prio_load", PC, 8'h55);

      from_mem(8'hFF); load_AR = 1;
      tick();
      bus_selectors = 3'd1; load_AR = 1;
      tick();
      chk("self_load", AR, 8'hFF);
      inc_AR = 1;
      tick();
      chk("wrap", AR, 8'h00);

      from_mem(8'h3C); load_DR = 1;
      tick();
      alu_op(3'b111);
      bus_selectors = 3'd4; memory_write = 1;
      #1;
      chk("st_we", {7'd0, mem_we}, 8'h01);
      chk("st_wdata", mem_wdata, 8'h3C);
      chk("st_addr", mem_addr, 8'h00);
      idle();

      bus_selectors = 3'd2; load_TR = 1;
      tick();
      bus_selectors = 3'd6;
      #1;
      chk("tr_bus", bus, 8'h55);
      idle();
      inc_TR = 1;
      tick();
      bus_selectors = 3'd6;
      #1;
      chk("tr_inc", bus, 8'h56);
      idle();

      from_mem(8'h99); load_DR = 1;
      tick();
      alu_mode = 3'b111; alu_enable = 1;
      tick();
      #2;
      reset = 1;
      #1;
      chk("arst_PC", PC, 8'h00);
      chk("arst_AC", AC, 8'h00);
      chk("arst_IR", IR, 8'h00);
      bus_selectors = 3'd3;
      #1;
      chk("arst_DR", bus, 8'h00);
      reset = 0;
      idle();
      load_AC = 1;
      tick();
      chk("post_rst_ac", AC, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
